// File: rtl/rat_pkg.sv
// Shared definitions for the rational datapath (rational_accum, rat_add, mod_div).
// Values stay generic here; the optional NORM stage is selected by RAT_ACC_NORM_EN in the top.
package rat_pkg;

    localparam int unsigned RAT_WIDTH = 32;

    typedef enum logic [1:0] {
        StAccum = 2'd0,
        StNorm  = 2'd1,
        StEmit  = 2'd2
    } rat_state_e;

    localparam int RAT_ZERO_NUM = 0;
    localparam int RAT_ONE_DEN  = 1;

    // Every rational handed downstream carries its sign in the numerator only (den > 0);
    // mod_div rounds on that assumption.
    localparam bit RAT_DEN_POSITIVE = 1'b1;

endpackage

// File: rtl/rat_add.sv
// Combinational a_num/a_den + b_num/b_den by cross-multiplication, truncated to WIDTH bits.
// ovf flags a numerator outside signed WIDTH or a denominator above 2^(WIDTH-1)-1.
module rat_add
    import rat_pkg::*;
#(
    parameter int unsigned WIDTH = RAT_WIDTH
) (
    input  logic signed [WIDTH-1:0] a_num,
    input  logic signed [WIDTH-1:0] a_den,
    input  logic signed [WIDTH:0]   b_num,
    input  logic signed [WIDTH:0]   b_den,
    output logic signed [WIDTH-1:0] sum_num,
    output logic signed [WIDTH-1:0] sum_den,
    output logic                    ovf
);

    // b is WIDTH+1 bits so a negated most-negative term is still exact.
    localparam int unsigned PW = 2 * WIDTH + 2;
    localparam logic signed [PW-1:0] DEN_MAX = (PW'(1) << (WIDTH - 1)) - PW'(1);

    logic signed [PW-1:0] an, ad, bn, bd;
    logic signed [PW-1:0] num_full, den_full, num_back;

    always_comb begin
        an       = a_num;
        ad       = a_den;
        bn       = b_num;
        bd       = b_den;
        num_full = an * bd + bn * ad;
        den_full = ad * bd;
        sum_num  = num_full[WIDTH-1:0];
        sum_den  = den_full[WIDTH-1:0];
        num_back = sum_num;
        ovf      = (num_back != num_full) || (den_full > DEN_MAX);
    end

endmodule

// File: rtl/rational_accum.sv
// Streaming accumulator of signed rational terms; emits num/den with den > 0 on the last term.
// Define RAT_ACC_NORM_EN to insert a NORM stage that strips common factors of two.
module rational_accum
    import rat_pkg::*;
#(
    parameter int unsigned WIDTH = RAT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_num,
    output logic [WIDTH-1:0] out_den,
    output logic             out_valid,
    input  logic             out_ack,
    output logic             ovf,
    output logic             err
);

    rat_state_e state;

    logic signed [WIDTH-1:0] acc_num, acc_den;
    logic signed [WIDTH:0]   term_num, term_den;
    logic signed [WIDTH-1:0] sum_num, sum_den;
    logic                    add_ovf;

    // Move the term's sign into its numerator before it meets the accumulator.
    always_comb begin
        term_num = $signed({in_num[WIDTH-1], in_num});
        term_den = $signed({in_den[WIDTH-1], in_den});
        if (RAT_DEN_POSITIVE && in_den[WIDTH-1]) begin
            term_num = -term_num;
            term_den = -term_den;
        end
    end

    rat_add #(
        .WIDTH(WIDTH)
    ) u_rat_add (
        .a_num  (acc_num),
        .a_den  (acc_den),
        .b_num  (term_num),
        .b_den  (term_den),
        .sum_num(sum_num),
        .sum_den(sum_den),
        .ovf    (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StAccum;
            acc_num <= WIDTH'(RAT_ZERO_NUM);
            acc_den <= WIDTH'(RAT_ONE_DEN);
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                StAccum: begin
                    if (in_valid) begin
                        if (in_den == '0) begin
                            err <= 1'b1;
                        end else begin
                            acc_num <= sum_num;
                            acc_den <= sum_den;
                            if (add_ovf) ovf <= 1'b1;
                        end
                        if (in_last) begin
`ifdef RAT_ACC_NORM_EN
                            state <= StNorm;
`else
                            state <= StEmit;
`endif
                        end
                    end
                end
`ifdef RAT_ACC_NORM_EN
                StNorm: begin
                    if (acc_num == '0) begin
                        acc_den <= WIDTH'(RAT_ONE_DEN);
                        state   <= StEmit;
                    end else if (!acc_num[0] && !acc_den[0]) begin
                        acc_num <= acc_num >>> 1;
                        acc_den <= acc_den >>> 1;
                    end else begin
                        state <= StEmit;
                    end
                end
`endif
                StEmit: begin
                    if (out_ack) begin
                        acc_num <= WIDTH'(RAT_ZERO_NUM);
                        acc_den <= WIDTH'(RAT_ONE_DEN);
                        ovf     <= 1'b0;
                        err     <= 1'b0;
                        state   <= StAccum;
                    end
                end
                default: state <= StAccum;
            endcase
        end
    end

    assign in_ready  = (state == StAccum);
    assign out_valid = (state == StEmit);
    assign out_num   = acc_num;
    assign out_den   = acc_den;

endmodule

// File: tb/tb_rational_accum.sv
// Directed bench for rational_accum: exact-arithmetic model of the running sum plus literal checks.
// Build with RAT_ACC_NORM_EN defined to exercise the NORM stage expectations.
module tb_rational_accum;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_num, in_den;
    logic         in_valid, in_last, in_ready;
    logic [W-1:0] out_num, out_den;
    logic         out_valid, out_ack, ovf, err;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of what the ports must show, in plain integer arithmetic.
    longint m_num, m_den;
    bit     m_ovf, m_err, m_valid, m_ready;
    bit     cmp_on = 1'b0;

    always #5 clk = ~clk;

    rational_accum #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_num   (in_num),
        .in_den   (in_den),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_num  (out_num),
        .out_den  (out_den),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .ovf      (ovf),
        .err      (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint trunc32(input longint v);
        logic signed [31:0] t;
        t = v[31:0];
        return longint'(t);
    endfunction

    function automatic void model_reset();
        m_num = 0; m_den = 1; m_ovf = 0; m_err = 0; m_valid = 0; m_ready = 1;
    endfunction

    // Exact rational addition; small test values keep longint products in range.
    function automatic void model_term(input longint n, input longint d);
        longint nn, nd;
        if (d == 0) begin
            m_err = 1;
            return;
        end
        if (d < 0) begin
            n = -n;
            d = -d;
        end
        nn = m_num * d + n * m_den;
        nd = m_den * d;
        if (nn > 64'sd2147483647 || nn < -64'sd2147483648 || nd > 64'sd2147483647) m_ovf = 1;
        m_num = trunc32(nn);
        m_den = trunc32(nd);
    endfunction

    // Strip common factors of two; returns the number of cycles that stage must take.
    function automatic int model_norm();
        int c = 1;
        if (m_num == 0) m_den = 1;
        else begin
            while ((m_num % 2 == 0) && (m_den % 2 == 0)) begin
                m_num = m_num / 2;
                m_den = m_den / 2;
                c++;
            end
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (cmp_on) begin
            check("out_num", out_num, m_num[31:0]);
            check("out_den", out_den, m_den[31:0]);
            check("ovf", ovf, m_ovf);
            check("err", err, m_err);
            check("out_valid", out_valid, m_valid);
            check("in_ready", in_ready, m_ready);
        end
    end

    task automatic term(input longint n, input longint d, input bit last);
        @(negedge clk);
        in_num   = n[31:0];
        in_den   = d[31:0];
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clk);
        model_term(n, d);
        if (last) begin
            m_ready = 0;
`ifdef RAT_ACC_NORM_EN
            cmp_on = 1'b0;
`else
            m_valid = 1;
`endif
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_sum();
`ifdef RAT_ACC_NORM_EN
        int c;
        int waited = 0;
        c = model_norm();
        while (!out_valid && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("norm_cycles", 64'(waited), 64'(c));
        m_valid = 1;
        cmp_on  = 1'b1;
        @(negedge clk);
`else
        @(negedge clk);
        check("latency_out_valid", out_valid, 1'b1);
`endif
    endtask

    task automatic ack();
        @(negedge clk);
        out_ack = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        out_ack = 1'b0;
        check("post_ack_num", out_num, 32'd0);
        check("post_ack_den", out_den, 32'd1);
        check("post_ack_ready", in_ready, 1'b1);
        check("post_ack_flags", {ovf, err, out_valid}, 3'b000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_num", out_num, 32'd0);
        check("rst_den", out_den, 32'd1);
        check("rst_ready", in_ready, 1'b1);
        check("rst_flags", {ovf, err, out_valid}, 3'b000);
    endtask

    initial begin
        rst = 1'b1; in_num = '0; in_den = '0; in_valid = 1'b0; in_last = 1'b0; out_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_num", out_num, 32'd0);
        check("reset_den", out_den, 32'd1);
        check("reset_ready", in_ready, 1'b1);
        check("reset_valid", out_valid, 1'b0);
        cmp_on = 1'b1;

        // 1/2 + 1/3 = 5/6, held until acknowledged
        term(1, 2, 0);
        term(1, 3, 1);
        finish_sum();
        check("sum1_num", out_num, 32'd5);
        check("sum1_den", out_den, 32'd6);
        repeat (3) @(negedge clk);
        ack();

        // single term with negative denominator
        term(3, -4, 1);
        finish_sum();
        check("neg_num", out_num, 32'hFFFF_FFFD);
        check("neg_den", out_den, 32'd4);
        ack();

        // 1/4 + 1/4
        term(1, 4, 0);
        term(1, 4, 1);
        finish_sum();
`ifdef RAT_ACC_NORM_EN
        check("quarter_num", out_num, 32'd1);
        check("quarter_den", out_den, 32'd2);
`else
        check("quarter_num", out_num, 32'd8);
        check("quarter_den", out_den, 32'd16);
`endif
        ack();

        // zero numerator
        term(0, 5, 1);
        finish_sum();
`ifdef RAT_ACC_NORM_EN
        check("zero_den", out_den, 32'd1);
`else
        check("zero_den", out_den, 32'd5);
`endif
        ack();

        // zero-denominator term is ignored but flagged
        term(1, 2, 0);
        term(5, 0, 0);
        term(1, 2, 1);
        finish_sum();
        check("err_flag", err, 1'b1);
`ifdef RAT_ACC_NORM_EN
        check("err_num", out_num, 32'd1);
`else
        check("err_num", out_num, 32'd4);
`endif
        ack();

        // numerator overflow
        term(1073741824, 1, 0);
        term(1073741824, 1, 1);
        finish_sum();
        check("ovf_flag", ovf, 1'b1);
        check("ovf_num", out_num, 32'h8000_0000);
        check("ovf_den", out_den, 32'd1);
        ack();

        // stall in EMIT with a term offered, then reset
        term(2, 3, 1);
        finish_sum();
        in_num = 32'd7; in_den = 32'd1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_ready", in_ready, 1'b0);
        end
        check("stall_num", out_num, 32'd2);
        do_reset();

        // reset mid-sum drops the partial
        term(1, 2, 0);
        check("partial_den", out_den, 32'd2);
        do_reset();

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
